// File: rtl/alu_pkg.sv
// Shared ALU encodings: ALUControl operation codes (also used by the ALU decoder)
// and the state encoding of the iterative multiplier FSM.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_MUL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/exec_alu_if.sv
// Execute-stage ALU port bundle: decoder/hazard side drives master, the ALU is slave.
interface exec_alu_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             flush_i;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             busy_o;
  logic             mul_done_o;

  modport master (
    output valid_i, flush_i, ALUControl, SrcA, SrcB,
    input  ALUResult, Zero, busy_o, mul_done_o
  );

  modport slave (
    input  valid_i, flush_i, ALUControl, SrcA, SrcB,
    output ALUResult, Zero, busy_o, mul_done_o
  );
endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier (low WIDTH bits of the product) with IDLE/RUN/DONE FSM.
// Define EXEC_ALU_RADIX4_MUL_EN for radix-4 (2 multiplier bits per cycle); default is radix-2.
module mul_iter import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             idle,
  output logic             run,
  output logic             done,
  output logic [WIDTH-1:0] product
);
`ifdef EXEC_ALU_RADIX4_MUL_EN
  localparam int N_ITER = WIDTH / 2;
  localparam int STEP   = 2;
`else
  localparam int N_ITER = WIDTH;
  localparam int STEP   = 1;
`endif
  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_ITER - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand_p0;
  logic [WIDTH-1:0] mplier_p0;
  logic [WIDTH-1:0] pp;
`ifdef EXEC_ALU_RADIX4_MUL_EN
  logic [WIDTH-1:0] mcand3_p0;

  always_comb begin
    pp = '0;
    case (mplier_p0[1:0])
      2'd1:    pp = mcand_p0;
      2'd2:    pp = mcand_p0 << 1;
      2'd3:    pp = mcand3_p0;
      default: pp = '0;
    endcase
  end
`else
  assign pp = mplier_p0[0] ? mcand_p0 : '0;
`endif

  assign idle    = (state == ST_IDLE);
  assign run     = (state == ST_RUN);
  assign done    = (state == ST_DONE);
  assign product = acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            cnt   <= CNT_LOAD;
            acc   <= '0;
          end
        end
        ST_RUN: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            acc <= acc + pp;
            if (cnt == '0) state <= ST_DONE;
            else           cnt   <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand shift registers carry no reset; they are reloaded on every start.
  always_ff @(posedge clk) begin
    if (idle && start) begin
      mcand_p0  <= a;
      mplier_p0 <= b;
`ifdef EXEC_ALU_RADIX4_MUL_EN
      mcand3_p0 <= a + (a << 1);
`endif
    end else if (run) begin
      mcand_p0  <= mcand_p0 << STEP;
      mplier_p0 <= mplier_p0 >> STEP;
`ifdef EXEC_ALU_RADIX4_MUL_EN
      mcand3_p0 <= mcand3_p0 << STEP;
`endif
    end
  end

endmodule

// File: rtl/exec_alu.sv
// Execute-stage ALU: combinational single-cycle ops, result mux and MUL stall logic.
// MUL iterates in mul_iter; EXEC_ALU_RADIX4_MUL_EN selects its radix-4 variant.
module exec_alu import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  exec_alu_if.slave alu
);
  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0]         shamt;
  logic signed [WIDTH-1:0] src_a_s;
  logic signed [WIDTH-1:0] src_b_s;
  logic                    slt_lt;
  logic                    sltu_lt;
  logic [WIDTH-1:0]        op_res;
  logic [WIDTH-1:0]        result;
  logic [WIDTH-1:0]        mul_prod;
  logic                    is_mul;
  logic                    mul_start;
  logic                    mul_idle;
  logic                    mul_run;
  logic                    mul_done;

  assign shamt   = alu.SrcB[SH_W-1:0];
  assign src_a_s = alu.SrcA;
  assign src_b_s = alu.SrcB;
  assign slt_lt  = src_a_s < src_b_s;
  assign sltu_lt = alu.SrcA < alu.SrcB;
  assign is_mul  = (alu.ALUControl == ALU_MUL);

  assign mul_start = alu.valid_i & is_mul & ~alu.flush_i & mul_idle;

  mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .flush   (alu.flush_i),
    .a       (alu.SrcA),
    .b       (alu.SrcB),
    .idle    (mul_idle),
    .run     (mul_run),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    op_res = '0;
    case (alu.ALUControl)
      ALU_ADD:  op_res = alu.SrcA + alu.SrcB;
      ALU_SUB:  op_res = alu.SrcA - alu.SrcB;
      ALU_AND:  op_res = alu.SrcA & alu.SrcB;
      ALU_OR:   op_res = alu.SrcA | alu.SrcB;
      ALU_SLL:  op_res = alu.SrcA << shamt;
      ALU_SLT:  op_res = {{(WIDTH-1){1'b0}}, slt_lt};
      ALU_SRL:  op_res = alu.SrcA >> shamt;
      ALU_SLTU: op_res = {{(WIDTH-1){1'b0}}, sltu_lt};
      ALU_SRA:  op_res = src_a_s >>> shamt;
      default:  op_res = '0;
    endcase
  end

  // While a multiply is in flight the instruction in EX is the MUL itself,
  // so the FSM state, not ALUControl, selects the result.
  always_comb begin
    result = op_res;
    if (mul_run)      result = '0;
    else if (mul_done) result = mul_prod;
    else if (is_mul)   result = '0;
  end

  assign alu.ALUResult  = result;
  assign alu.Zero       = (result == '0);
  assign alu.busy_o     = ~reset & ~alu.flush_i & ((mul_idle & alu.valid_i & is_mul) | mul_run);
  assign alu.mul_done_o = mul_done & ~alu.flush_i;

endmodule

// File: tb/tb_exec_alu.sv
// Self-checking bench for exec_alu: randomized ops and multiplies against a behavioural model.
module tb_exec_alu;
  import alu_pkg::*;

  localparam int WIDTH = 32;
`ifdef EXEC_ALU_RADIX4_MUL_EN
  localparam int MUL_BUSY = WIDTH / 2 + 1;
`else
  localparam int MUL_BUSY = WIDTH + 1;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  exec_alu_if #(.WIDTH(WIDTH)) bus ();

  exec_alu #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .alu   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int          sh = int'(b[4:0]);
    longint      sa = $signed(a);
    longint      sb = $signed(b);
    logic [63:0] ua = {32'b0, a};
    logic [63:0] ub = {32'b0, b};
    logic [63:0] t;
    case (op)
      ALU_ADD:  t = ua + ub;
      ALU_SUB:  t = ua + (64'h1_0000_0000 - ub);
      ALU_AND:  t = ua & ub;
      ALU_OR:   t = ua | ub;
      ALU_SLL:  t = ua * (64'd1 << sh);
      ALU_SRL:  t = ua / (64'd1 << sh);
      ALU_SRA:  t = sa >>> sh;
      ALU_SLT:  t = (sa < sb) ? 64'd1 : 64'd0;
      ALU_SLTU: t = (ua < ub) ? 64'd1 : 64'd0;
      ALU_MUL:  t = ua * ub;
      default:  t = 64'd0;
    endcase
    return t[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic z, output int busy_cnt,
                         output bit tmo, output logic busy_at_done);
    bus.valid_i    = 1'b1;
    bus.flush_i    = 1'b0;
    bus.ALUControl = ALU_MUL;
    bus.SrcA       = a;
    bus.SrcB       = b;
    busy_cnt       = 0;
    tmo            = 1'b1;
    res            = '0;
    z              = 1'b0;
    busy_at_done   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.mul_done_o === 1'b1) begin
        res          = bus.ALUResult;
        z            = bus.Zero;
        busy_at_done = bus.busy_o;
        tmo          = 1'b0;
        break;
      end
      if (bus.busy_o === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
    end
    step();
    bus.valid_i    = 1'b0;
    bus.ALUControl = ALU_ADD;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.valid_i    = 1'b1;
    bus.flush_i    = 1'b0;
    bus.ALUControl = ALU_MUL;
    bus.SrcA       = 32'd5;
    bus.SrcB       = 32'd7;
    #12;
    n_cmp++;
    if (bus.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_o);
    end
    n_cmp++;
    if (bus.mul_done_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b want 0", bus.mul_done_o);
    end
    bus.ALUControl = ALU_ADD;
    #1;
    n_cmp++;
    if (bus.ALUResult !== 32'd12) begin
      n_fail++; $display("FAIL reset_add_comb: got %h want %h", bus.ALUResult, 32'd12);
    end
    step();
    reset       = 1'b0;
    bus.valid_i = 1'b0;
    step();
  endtask

  task automatic test_single_ops();
    logic [3:0]  ops  [9] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL,
                              ALU_SLT, ALU_SRL, ALU_SLTU, ALU_SRA};
    logic [31:0] exps [9] = '{32'h8000_0014, 32'h8000_000C, 32'h0000_0000, 32'h8000_0014,
                              32'h0000_0100, 32'h0000_0001, 32'h0800_0001, 32'h0000_0000,
                              32'hF800_0001};
    logic [31:0] a, b, e;
    logic [3:0]  op;
    bus.valid_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.ALUControl = ops[i];
      bus.SrcA       = 32'h8000_0010;
      bus.SrcB       = 32'h0000_0004;
      @(negedge clk);
      n_cmp++;
      if (bus.ALUResult !== exps[i] || bus.Zero !== (exps[i] == 0) || bus.busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL fixed_op %b: got res=%h zero=%b busy=%b want res=%h zero=%b busy=0",
                 ops[i], bus.ALUResult, bus.Zero, bus.busy_o, exps[i], exps[i] == 0);
      end
      step();
    end
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 8)];
      a  = $urandom;
      b  = (i % 3 == 0) ? a : $urandom;
      e  = ref_alu(op, a, b);
      bus.ALUControl = op;
      bus.SrcA       = a;
      bus.SrcB       = b;
      @(negedge clk);
      n_cmp++;
      if (bus.ALUResult !== e || bus.Zero !== (e == 0) || bus.busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_op %b a=%h b=%h: got res=%h zero=%b busy=%b want res=%h zero=%b busy=0",
                 op, a, b, bus.ALUResult, bus.Zero, bus.busy_o, e, e == 0);
      end
      step();
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic test_undefined();
    logic [3:0] codes [5] = '{4'b1010, 4'b1001, 4'b1011, 4'b1100, 4'b1110};
    bus.valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.ALUControl = codes[i];
      bus.SrcA       = $urandom | 32'h1;
      bus.SrcB       = $urandom | 32'h1;
      @(negedge clk);
      n_cmp++;
      if (bus.ALUResult !== 32'd0 || bus.Zero !== 1'b1 || bus.busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL undef_op %b: got res=%h zero=%b busy=%b want res=0 zero=1 busy=0",
                 codes[i], bus.ALUResult, bus.Zero, bus.busy_o);
      end
      step();
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic check_mul(input string name, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res, e;
    logic        z, bd;
    int          bc;
    bit          tmo;
    e = ref_alu(ALU_MUL, a, b);
    run_mul(a, b, res, z, bc, tmo, bd);
    n_cmp++;
    if (tmo || res !== e || z !== (e == 0)) begin
      n_fail++;
      $display("FAIL %s %h*%h: got res=%h zero=%b timeout=%0d want res=%h zero=%b",
               name, a, b, res, z, tmo, e, e == 0);
    end
    n_cmp++;
    if (bc != MUL_BUSY || bd !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy: got %0d busy cycles (busy at done=%b) want %0d (0)",
               name, bc, bd, MUL_BUSY);
    end
  endtask

  task automatic test_mul();
    check_mul("mul_3x5", 32'd3, 32'd5);
    check_mul("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_mul("mul_wrap0", 32'h0001_0000, 32'h0001_0000);
    for (int i = 0; i < 6; i++) check_mul("mul_rand", $urandom, $urandom);
    check_mul("mul_small", $urandom_range(0, 1000), $urandom_range(0, 1000));
  endtask

  task automatic test_back_to_back();
    check_mul("b2b_first", $urandom, $urandom);
    check_mul("b2b_second", $urandom, $urandom);
    @(negedge clk);
    n_cmp++;
    if (bus.busy_o !== 1'b0 || bus.mul_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_restart: got busy=%b done=%b want 0 0", bus.busy_o, bus.mul_done_o);
    end
    step();
  endtask

  task automatic test_flush();
    bus.valid_i    = 1'b1;
    bus.flush_i    = 1'b0;
    bus.ALUControl = ALU_MUL;
    bus.SrcA       = $urandom;
    bus.SrcB       = $urandom;
    for (int i = 0; i < 10; i++) step();
    @(negedge clk);
    n_cmp++;
    if (bus.busy_o !== 1'b1 || bus.ALUResult !== 32'd0) begin
      n_fail++;
      $display("FAIL run_state: got busy=%b res=%h want busy=1 res=0", bus.busy_o, bus.ALUResult);
    end
    @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.busy_o !== 1'b0 || bus.mul_done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_abort cycle %0d: got busy=%b done=%b want 0 0",
                 i, bus.busy_o, bus.mul_done_o);
      end
      step();
    end
    check_mul("after_flush_7x6", 32'd7, 32'd6);
  endtask

  task automatic test_reset_mid_run();
    bus.valid_i    = 1'b1;
    bus.flush_i    = 1'b0;
    bus.ALUControl = ALU_MUL;
    bus.SrcA       = 32'd9;
    bus.SrcB       = 32'd9;
    for (int i = 0; i < 6; i++) step();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.busy_o !== 1'b0 || bus.mul_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: got busy=%b done=%b want 0 0", bus.busy_o, bus.mul_done_o);
    end
    step();
    reset       = 1'b0;
    bus.valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.busy_o !== 1'b0 || bus.mul_done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset cycle %0d: got busy=%b done=%b want 0 0",
                 i, bus.busy_o, bus.mul_done_o);
      end
      step();
    end
    check_mul("after_reset_2x2", 32'd2, 32'd2);
  endtask

  initial begin
    bus.valid_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.ALUControl = ALU_ADD;
    bus.SrcA       = '0;
    bus.SrcB       = '0;
    test_reset();
    test_single_ops();
    test_undefined();
    test_mul();
    test_back_to_back();
    test_flush();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
